zymouse_axil_regs: RTL and testbench
====================================

ZYMOUSE_AXIL_REGS -- requirements
Module: zymouse_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 words).
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
REQ-004 SHALL have these AXI4-Lite and user ports:
- AWADDR  in  4  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  4  read address.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read valid.
- RREADY  in  1  read ready.
- regs_out  out  128  {reg3,reg2,reg1,reg0}.
- wr_pulse  out  4  one-hot, one cycle, register written.

Function
REQ-005 SHALL decode the word index from ADDR[3:2]; ADDR[1:0] SHALL be ignored; all four registers SHALL be read/write.
REQ-006 Write FSM SHALL have states W_IDLE and W_RESP.
REQ-007 In W_IDLE, AWREADY SHALL be 1 until AW is captured, and WREADY SHALL be 1 until W is captured.
REQ-008 AW and W SHALL be captured independently, in either order or in the same cycle; a captured channel SHALL hold its READY at 0 until the write completes.
REQ-009 On the edge where both AW and W are held or handshaking, the FSM SHALL:
- update the register bytes enabled by WSTRB; bytes with WSTRB=0 SHALL be unchanged;
- pulse the matching wr_pulse bit in the following cycle;
- enter W_RESP.
REQ-010 In W_RESP, BVALID=1 and BRESP=00 (OKAY); AWREADY and WREADY SHALL be 0; BVALID SHALL hold until BREADY=1, then the FSM SHALL return to W_IDLE on that edge.
REQ-011 Latency: with AW and W in the same cycle at edge N, BVALID SHALL be high in cycle N+1.
REQ-012 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
REQ-013 On an AR handshake at edge N, RDATA SHALL be registered from the register array and RVALID SHALL assert in cycle N+1.
REQ-014 RDATA and RVALID SHALL be stable until RREADY=1; RRESP SHALL always be 00.
REQ-015 Read and write FSMs SHALL run concurrently.
REQ-016 If a write commit and an AR handshake to the same register occur on the same edge, RDATA SHALL return the pre-write value.
REQ-017 WSTRB=0000 SHALL complete normally with an OKAY response, no data change, and no wr_pulse.
REQ-018 regs_out SHALL reflect register contents combinationally from the flops, with no extra latency.

Reset
REQ-019 ARESETN low SHALL, asynchronously:
- clear all registers, RDATA, BRESP and RRESP to 0;
- drive AWREADY, WREADY, BVALID, ARREADY, RVALID and wr_pulse to 0;
- put the FSMs in W_IDLE and R_IDLE with no captured channels.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no response issued.
REQ-021 AWREADY, WREADY and ARREADY SHALL rise in the first cycle after ARESETN deasserts.

Verification
REQ-022 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all responses OKAY, wr_pulse 0001,0010,0100,1000.
REQ-023 W presented 3 cycles before AW to 0x8 with data 0xDEADBEEF -> WREADY drops after the W handshake, the write completes on AW, and reg2=0xDEADBEEF.
REQ-024 reg1=0x11223344, then write 0xAABBCCDD with WSTRB=0101 -> reg1=0x11BB33DD.
REQ-025 BREADY held low 5 cycles -> BVALID stays high, AWREADY and WREADY stay 0, and a new AWVALID is not accepted until the B handshake.
REQ-026 RREADY held low 4 cycles while a write to another register completes -> RDATA stays stable and the write response is independent of the pending read.
REQ-027 ARESETN pulsed low while BVALID=1 -> BVALID=0 immediately, regs_out=0, and a following write/read works normally.

Source files
------------

// File: rtl/zymouse_axil_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers, byte strobes and
// a one-cycle per-register write pulse. Read and write paths run independently.
module zymouse_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_out,
    output logic [3:0]                      wr_pulse
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    localparam logic W_IDLE = 1'b0;
    localparam logic W_RESP = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;
    logic                               w_state, r_state;
    logic                               aw_held, w_held;
    logic [1:0]                         aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]      w_data;
    logic [NB-1:0]                      w_strb;

    logic                               aw_hs, w_hs, aw_have, w_have;
    logic [1:0]                         cm_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]      cm_data;
    logic [NB-1:0]                      cm_strb;
    logic                               unused_ok;

    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign BRESP    = 2'b00;
    assign RRESP    = 2'b00;
    assign regs_out = regs;

    // A channel is "had" when it is captured earlier or handshaking this edge;
    // the commit uses the live bus when the handshake is happening now.
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign aw_have = aw_hs || aw_held;
    assign w_have  = w_hs || w_held;
    assign cm_idx  = aw_hs ? AWADDR[3:2] : aw_idx;
    assign cm_data = w_hs ? WDATA : w_data;
    assign cm_strb = w_hs ? WSTRB : w_strb;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            wr_pulse <= '0;
            regs     <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (aw_have && w_have) begin
                        for (int b = 0; b < NB; b++)
                            if (cm_strb[b]) regs[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
                        if (|cm_strb) wr_pulse <= 4'b0001 << cm_idx;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held <= 1'b1;
                            aw_idx  <= AWADDR[3:2];
                        end
                        if (w_hs) begin
                            w_held <= 1'b1;
                            w_data <= WDATA;
                            w_strb <= WSTRB;
                        end
                        AWREADY <= !aw_have;
                        WREADY  <= !w_have;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs before any same-edge write lands, returning the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        RDATA   <= regs[ARADDR[3:2]];
                        RVALID  <= 1'b1;
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zymouse_axil_regs.sv
// Scoreboard bench for zymouse_axil_regs: read expectations are queued at the
// AR handshake and compared when the R beat is accepted.
module tb_zymouse_axil_regs;
    logic        ACLK, ARESETN;
    logic [3:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB, wr_pulse;
    logic [1:0]  BRESP, RRESP;
    logic [127:0] regs_out;

    logic [31:0] mdl [4];
    logic [31:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    zymouse_axil_regs dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    initial begin
        ACLK = 0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mdl_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    function automatic void mdl_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[addr[3:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Present AW and W together; return one step after the commit edge.
    task automatic drive_and_commit(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_ok, w_ok, aw_f, w_f;
        int t;
        aw_ok = 0; w_ok = 0; t = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1;
        while (!(aw_ok && w_ok) && t < 20) begin
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            step();
            if (aw_f) begin aw_ok = 1; AWVALID = 0; end
            if (w_f)  begin w_ok = 1;  WVALID = 0;  end
            t++;
        end
        n_vec++;
        if (!(aw_ok && w_ok)) begin
            n_err++;
            $display("FAIL aw_w_handshake: aw=%0b w=%0b after %0d cycles, required both", aw_ok, w_ok, t);
            AWVALID = 0; WVALID = 0;
        end else begin
            mdl_write(addr, data, strb);
        end
    endtask

    task automatic finish_b(input logic [3:0] exp_pulse, input int bdelay);
        n_vec++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            n_err++; $display("FAIL b_resp: bvalid=%b bresp=%b, required 1/00", BVALID, BRESP);
        end
        n_vec++;
        if (wr_pulse !== exp_pulse) begin
            n_err++; $display("FAIL wr_pulse: got %b, required %b", wr_pulse, exp_pulse);
        end
        BREADY = 0;
        for (int i = 0; i < bdelay; i++) begin
            step();
            n_vec++;
            if (BVALID !== 1'b1 || AWREADY !== 1'b0 || WREADY !== 1'b0 || wr_pulse !== 4'b0) begin
                n_err++;
                $display("FAIL b_stall: bvalid=%b awready=%b wready=%b pulse=%b, required 1/0/0/0000",
                         BVALID, AWREADY, WREADY, wr_pulse);
            end
        end
        BREADY = 1;
        step();
        BREADY = 0;
        n_vec++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_err++; $display("FAIL b_done: bvalid=%b awready=%b, required 0/1", BVALID, AWREADY);
        end
    endtask

    task automatic ar_issue(input logic [3:0] addr);
        bit ok, f;
        int t;
        ok = 0; t = 0;
        ARADDR = addr; ARVALID = 1;
        while (!ok && t < 20) begin
            f = ARVALID && ARREADY;
            if (f) exp_q.push_back(mdl[addr[3:2]]);
            step();
            if (f) begin ok = 1; ARVALID = 0; end
            t++;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL ar_handshake: timeout after %0d cycles", t);
            ARVALID = 0;
        end
    endtask

    task automatic r_collect(input int rdelay);
        logic [31:0] first, e;
        int t;
        t = 0;
        while (RVALID !== 1'b1 && t < 20) begin step(); t++; end
        first = RDATA;
        RREADY = 0;
        for (int i = 0; i < rdelay; i++) begin
            step();
            n_vec++;
            if (RVALID !== 1'b1 || RDATA !== first) begin
                n_err++; $display("FAIL r_stall: rvalid=%b rdata=%h, required 1/%h", RVALID, RDATA, first);
            end
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL r_scoreboard: rvalid=%b with no expected read queued", RVALID);
        end else begin
            e = exp_q.pop_front();
            if (RVALID !== 1'b1 || RDATA !== e || RRESP !== 2'b00) begin
                n_err++;
                $display("FAIL r_data: rvalid=%b rdata=%h rresp=%b, required 1/%h/00", RVALID, RDATA, RRESP, e);
            end
        end
        RREADY = 1;
        step();
        RREADY = 0;
        n_vec++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
            n_err++; $display("FAIL r_done: rvalid=%b arready=%b, required 0/1", RVALID, ARREADY);
        end
    endtask

    task automatic write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
        drive_and_commit(addr, d, s);
        finish_b((s != 0) ? (4'b0001 << addr[3:2]) : 4'b0000, 0);
        n_vec++;
        if (regs_out !== mdl_flat()) begin
            n_err++; $display("FAIL regs_out: got %h, required %h", regs_out, mdl_flat());
        end
    endtask

    task automatic test_reset();
        ARESETN = 0;
        AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        repeat (3) step();
        n_vec++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID} !== 5'b0 || wr_pulse !== 4'b0 ||
            regs_out !== 128'b0 || RDATA !== 32'b0 || BRESP !== 2'b0 || RRESP !== 2'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy/vld=%b pulse=%b regs=%h rdata=%h, required all 0",
                     {AWREADY, WREADY, BVALID, ARREADY, RVALID}, wr_pulse, regs_out, RDATA);
        end
        ARESETN = 1;
        step();
        n_vec++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL ready_after_reset: got %b, required 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) write(4'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) begin
            ar_issue(4'(i * 4 + i));  // low address bits are don't-care
            r_collect(0);
        end
        n_vec++;
        if (regs_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            n_err++; $display("FAIL basic_regs: got %h, required 4/3/2/1", regs_out);
        end
    endtask

    task automatic test_w_before_aw();
        WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1;
        step();
        WVALID = 0;
        n_vec++;
        if (WREADY !== 1'b0) begin
            n_err++; $display("FAIL w_first_wready: got %b, required 0", WREADY);
        end
        repeat (2) step();
        n_vec++;
        if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_err++; $display("FAIL w_first_wait: wready=%b bvalid=%b awready=%b, required 0/0/1",
                              WREADY, BVALID, AWREADY);
        end
        AWADDR = 4'h8; AWVALID = 1;
        step();
        AWVALID = 0;
        mdl_write(4'h8, 32'hDEADBEEF, 4'hF);
        finish_b(4'b0100, 0);
        n_vec++;
        if (regs_out[95:64] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL w_first_reg2: got %h, required deadbeef", regs_out[95:64]);
        end
    endtask

    task automatic test_strobe();
        write(4'h4, 32'h11223344, 4'hF);
        write(4'h4, 32'hAABBCCDD, 4'b0101);
        n_vec++;
        if (regs_out[63:32] !== 32'h11BB33DD) begin
            n_err++; $display("FAIL strobe_reg1: got %h, required 11bb33dd", regs_out[63:32]);
        end
        write(4'h8, 32'h12345678, 4'b0000);
        ar_issue(4'h8);
        r_collect(0);
    endtask

    task automatic test_bready_stall();
        drive_and_commit(4'h0, 32'hCAFEF00D, 4'hF);
        AWADDR = 4'h4; AWVALID = 1;
        finish_b(4'b0001, 5);
        drive_and_commit(4'h4, 32'h0BADF00D, 4'b1100);
        finish_b(4'b0010, 0);
        n_vec++;
        if (regs_out !== mdl_flat()) begin
            n_err++; $display("FAIL stall_regs: got %h, required %h", regs_out, mdl_flat());
        end
    endtask

    task automatic test_read_stall();
        ar_issue(4'h0);
        drive_and_commit(4'hC, 32'h5A5A5A5A, 4'hF);
        finish_b(4'b1000, 0);
        r_collect(2);
    endtask

    task automatic test_same_edge();
        n_vec++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_err++; $display("FAIL same_edge_ready: got %b, required 111", {AWREADY, WREADY, ARREADY});
        end
        AWADDR = 4'h4; WDATA = 32'h76543210; WSTRB = 4'hF; ARADDR = 4'h4;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        exp_q.push_back(mdl[1]);
        step();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        mdl_write(4'h4, 32'h76543210, 4'hF);
        finish_b(4'b0010, 0);
        r_collect(0);
        ar_issue(4'h4);
        r_collect(0);
    endtask

    task automatic test_reset_mid();
        drive_and_commit(4'hC, 32'hFFFF0000, 4'hF);
        #2 ARESETN = 0;
        #1;
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        n_vec++;
        if (BVALID !== 1'b0 || regs_out !== 128'b0 || AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
            n_err++; $display("FAIL reset_mid: bvalid=%b regs=%h awready=%b arready=%b, required 0",
                              BVALID, regs_out, AWREADY, ARREADY);
        end
        BREADY = 1;
        step();
        ARESETN = 1;
        BREADY = 0;
        step();
        n_vec++;
        if ({AWREADY, WREADY, ARREADY, BVALID} !== 4'b1110) begin
            n_err++; $display("FAIL after_reset_mid: rdy/bvalid=%b, required 1110",
                              {AWREADY, WREADY, ARREADY, BVALID});
        end
        write(4'h8, 32'h00C0FFEE, 4'hF);
        ar_issue(4'h8);
        r_collect(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_bready_stall();
        test_read_stall();
        test_same_edge();
        test_reset_mid();
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
